// File: rtl/pixel_aer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_aer_pkg
// Description : Shared defaults, polarity/type encodings and the event word
//               layout for the pixel AER streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_aer_pkg;

  localparam int c_def_rows       = 8;
  localparam int c_def_cols       = 8;
  localparam int c_def_ts_w       = 16;
  localparam int c_def_fifo_depth = 8;

  // Polarity field: ON events carry 1, OFF events carry 0.
  typedef enum logic {
    POL_OFF = 1'b0,
    POL_ON  = 1'b1
  } pol_e;

  // Type field: pixel events vs. wall-clock wrap markers.
  typedef enum logic {
    EVT_PIXEL = 1'b0,
    EVT_WRAP  = 1'b1
  } evt_type_e;

  // Event word layout for the default array size, MSB first.
  typedef struct packed {
    evt_type_e                       evt_type;
    logic [$clog2(c_def_rows)-1:0]   x;
    logic [$clog2(c_def_cols)-1:0]   y;
    logic [c_def_ts_w-1:0]           ts;
    pol_e                            pol;
  } aer_evt_t;

endpackage
`default_nettype wire

// File: rtl/aer_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aer_event_fifo
// Description : Synchronous event buffer with occupancy count. A push is
//               accepted when full if a pop frees a slot on the same edge.
//               Output data reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module aer_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] cnt_o
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr;
  logic [c_aw-1:0]  r_rd;
  logic [c_aw:0]    r_cnt;
  logic             w_pop;
  logic             w_push;

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == (c_aw+1)'(DEPTH));
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = empty_o ? '0 : r_mem[r_rd];
  assign cnt_o   = r_cnt;

  // Storage array, written at the tail slot.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{c_aw{1'b0}}, w_push} - {{c_aw{1'b0}}, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_aer_streamer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_aer_streamer
// Description : Round-robin arbiter over a pixel request array that stamps
//               each winner with the wall clock and buffers the events for
//               a valid/ready stream. Define PIXEL_AER_TS_WRAP_EN to insert
//               a wrap marker event whenever the wall clock rolls over.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_aer_streamer
  import pixel_aer_pkg::*;
#(
  parameter int ROWS       = c_def_rows,
  parameter int COLS       = c_def_cols,
  parameter int TS_W       = c_def_ts_w,
  parameter int FIFO_DEPTH = c_def_fifo_depth
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [ROWS-1:0][COLS-1:0][1:0]            req_i,
  output logic [ROWS-1:0][COLS-1:0]                 gnt_o,
  output logic [$clog2(ROWS)+$clog2(COLS)+TS_W+1:0] evt_data_o,
  output logic                                      evt_valid_o,
  input  logic                                      evt_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]               fifo_cnt_o,
  output logic                                      idle_o
);

  localparam int RA_W     = $clog2(ROWS);
  localparam int CA_W     = $clog2(COLS);
  localparam int EVT_W    = 1 + RA_W + CA_W + TS_W + 1;
  localparam int c_npix   = ROWS * COLS;
  localparam int c_idx_w  = $clog2(c_npix);

  logic [c_npix-1:0]  w_req_nz;
  logic [c_npix-1:0]  w_req_on;
  logic [c_npix-1:0]  w_elig;
  logic [c_npix-1:0]  w_win_oh;
  logic [c_npix-1:0]  r_pend;
  logic [c_npix-1:0]  r_gnt;
  logic [c_idx_w-1:0] r_last;
  logic [c_idx_w-1:0] w_win;
  logic [c_idx_w-1:0] w_scan_sel;
  int                 w_scan_idx;
  logic               w_found;
  logic               r_run;
  logic [TS_W-1:0]    r_ts;
  logic [TS_W-1:0]    w_ts_next;
  logic [RA_W-1:0]    w_x;
  logic [CA_W-1:0]    w_y;
  pol_e               w_pol;
  logic [EVT_W-1:0]   w_pix_evt;
  logic [EVT_W-1:0]   w_wrap_evt;
  logic [EVT_W-1:0]   w_push_data;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_can_push;
  logic               w_wrap_req;
  logic               w_pix_push;
  logic               w_push;

  // Flatten the 2-D request/grant arrays onto linear index r*COLS+c.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign w_req_nz[r*COLS+c] = |req_i[r][c];
      assign w_req_on[r*COLS+c] = req_i[r][c][0];
      assign gnt_o[r][c]        = r_gnt[r*COLS+c];
    end
  end

  // r_run holds arbitration off until the first edge after reset release.
  assign w_elig = w_req_nz & ~r_pend & {c_npix{r_run}};

  // Round-robin scan starting just after the last winner.
  always_comb begin
    w_scan_idx = 0;
    w_scan_sel = '0;
    w_found    = 1'b0;
    w_win      = '0;
    for (int k = 1; k <= c_npix; k++) begin
      w_scan_idx = int'(r_last) + k;
      if (w_scan_idx >= c_npix) w_scan_idx = w_scan_idx - c_npix;
      w_scan_sel = c_idx_w'(w_scan_idx);
      if (!w_found && w_elig[w_scan_sel]) begin
        w_found = 1'b1;
        w_win   = w_scan_sel;
      end
    end
  end

  assign w_win_oh   = {{(c_npix-1){1'b0}}, 1'b1} << w_win;
  assign w_x        = RA_W'(w_win / COLS);
  assign w_y        = CA_W'(w_win % COLS);
  assign w_pol      = w_req_on[w_win] ? POL_ON : POL_OFF;
  // Events carry the value the wall clock takes at the write edge.
  assign w_ts_next  = r_ts + 1'b1;
  assign w_pix_evt  = {EVT_PIXEL, w_x, w_y, w_ts_next, w_pol};
  assign w_wrap_evt = {EVT_WRAP, {RA_W{1'b0}}, {CA_W{1'b0}}, {TS_W{1'b0}}, POL_OFF};

  assign w_pop      = evt_valid_o && evt_ready_i;
  assign w_can_push = !w_full || w_pop;

`ifdef PIXEL_AER_TS_WRAP_EN
  logic r_wrap_pend;

  // A wrap marker is requested at rollover and retried until it lands.
  assign w_wrap_req = (r_ts == {TS_W{1'b1}}) || r_wrap_pend;

  // Remember a wrap marker that a full buffer turned away.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_wrap_pend <= 1'b0;
    else         r_wrap_pend <= w_wrap_req && !w_can_push;
  end
`else
  assign w_wrap_req = 1'b0;
`endif

  assign w_pix_push  = w_found && w_can_push && !w_wrap_req;
  assign w_push      = w_pix_push || (w_wrap_req && w_can_push);
  assign w_push_data = w_wrap_req ? w_wrap_evt : w_pix_evt;

  assign evt_valid_o = !w_empty;
  assign idle_o      = !(|w_elig) && w_empty;

  // Wall clock, pending mask, round-robin pointer and grant pulse.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_run  <= 1'b0;
      r_ts   <= '0;
      r_pend <= '0;
      r_last <= c_idx_w'(c_npix - 1);
      r_gnt  <= '0;
    end else begin
      r_run  <= 1'b1;
      r_ts   <= w_ts_next;
      r_pend <= (r_pend & w_req_nz) | (w_pix_push ? w_win_oh : '0);
      r_gnt  <= w_pix_push ? w_win_oh : '0;
      if (w_pix_push) r_last <= w_win;
    end
  end

  aer_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (w_pop),
    .data_o  (evt_data_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .cnt_o   (fifo_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_pixel_aer_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_aer_streamer
// Description : Scoreboard bench for pixel_aer_streamer (4x4 array, 8-bit
//               timestamps, 4-entry buffer). Expected events are queued by
//               the stimulus and checked by an independent output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_aer_streamer;

  logic                  clk;
  logic                  reset_i;
  logic [3:0][3:0][1:0]  req;
  logic [3:0][3:0]       gnt_o;
  logic [13:0]           evt_data_o;
  logic                  evt_valid_o;
  logic                  evt_ready_i;
  logic [2:0]            fifo_cnt_o;
  logic                  idle_o;

  logic [13:0]           exp_q[$];
  logic [13:0]           mon_e;
  int                    checks = 0;
  int                    errors = 0;
  int                    gnt_total = 0;
  int                    gnt12 = 0;

  pixel_aer_streamer #(
    .ROWS       (4),
    .COLS       (4),
    .TS_W       (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_i       (req),
    .gnt_o       (gnt_o),
    .evt_data_o  (evt_data_o),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .fifo_cnt_o  (fifo_cnt_o),
    .idle_o      (idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event word {type, x(row), y(col), ts, pol}.
  function automatic logic [13:0] ev(input int t, input int r, input int c,
                                     input int ts, input int p);
    logic [1:0] rr;
    logic [1:0] cc;
    logic [7:0] tt;
    rr = 2'(r);
    cc = 2'(c);
    tt = 8'(ts);
    return {t[0], rr, cc, tt, p[0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Output monitor: a transfer happens at the next posedge when valid&&ready.
  always @(negedge clk) begin
    if (!reset_i && evt_valid_o && evt_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt actual=%h required=none", evt_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("evt_data", {18'b0, evt_data_o}, {18'b0, mon_e});
      end
    end
  end

  // Grant pulse counters.
  always @(negedge clk) begin
    gnt_total += $countones(gnt_o);
    gnt12     += int'(gnt_o[1][2]);
  end

  // Advance n edges and settle just after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset_i = 1'b1;
    req     = '0;
    edges(2);
    exp_q.delete();
    gnt_total = 0;
    gnt12     = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_i     = 1'b1;
    req         = '0;
    evt_ready_i = 1'b1;
    edges(2);

    // Reset state
    chk("rst_gnt",   gnt_o, 0);
    chk("rst_valid", evt_valid_o, 0);
    chk("rst_cnt",   fifo_cnt_o, 0);
    chk("rst_idle",  idle_o, 1);
    chk("rst_data",  evt_data_o, 0);

    // Single held request: one event, a second only after drop/re-assert
    apply_reset();
    evt_ready_i = 1'b1;
    req[1][2]   = 2'b01;
    exp_q.push_back(ev(0, 1, 2, 2, 1));
    exp_q.push_back(ev(0, 1, 2, 13, 1));
    release_reset();
    edges(10);
    chk("a_gnt_once", gnt12, 1);
    req[1][2] = 2'b00;
    edges(2);
    req[1][2] = 2'b01;
    edges(6);
    chk("a_gnt_twice", gnt12, 2);
    chk("a_gnt_total", gnt_total, 2);
    req = '0;
    wait_drain();

    // Three simultaneous requests: round-robin order, consecutive ts
    apply_reset();
    req[0][0] = 2'b01;
    req[0][3] = 2'b10;
    req[3][3] = 2'b01;
    exp_q.push_back(ev(0, 0, 0, 2, 1));
    exp_q.push_back(ev(0, 0, 3, 3, 0));
    exp_q.push_back(ev(0, 3, 3, 4, 1));
    release_reset();
    edges(1);
    chk("b_no_gnt_first", gnt_o, 0);
    edges(8);
    req = '0;
    wait_drain();
    chk("b_gnt_total", gnt_total, 3);

    // Backpressure: buffer fills at 4, remaining two wait without loss
    apply_reset();
    evt_ready_i = 1'b0;
    req[0][1] = 2'b01;
    req[0][2] = 2'b01;
    req[1][1] = 2'b01;
    req[2][0] = 2'b01;
    req[2][2] = 2'b01;
    req[3][2] = 2'b01;
    exp_q.push_back(ev(0, 0, 1, 2, 1));
    exp_q.push_back(ev(0, 0, 2, 3, 1));
    exp_q.push_back(ev(0, 1, 1, 4, 1));
    exp_q.push_back(ev(0, 2, 0, 5, 1));
    exp_q.push_back(ev(0, 2, 2, 11, 1));
    exp_q.push_back(ev(0, 3, 2, 12, 1));
    release_reset();
    edges(10);
    chk("c_cnt_full",   fifo_cnt_o, 4);
    chk("c_gnt_held",   gnt_total, 4);
    chk("c_valid",      evt_valid_o, 1);
    chk("c_head_hold",  evt_data_o, ev(0, 0, 1, 2, 1));
    evt_ready_i = 1'b1;
    edges(4);
    chk("c_gnt_all", gnt_total, 6);
    req = '0;
    wait_drain();

    // Both polarity bits set: ON wins
    apply_reset();
    req[2][1] = 2'b11;
    exp_q.push_back(ev(0, 2, 1, 2, 1));
    release_reset();
    edges(6);
    req = '0;
    wait_drain();

    // Reset with buffered events discards them immediately
    apply_reset();
    evt_ready_i = 1'b0;
    req[0][0] = 2'b01;
    req[0][1] = 2'b01;
    req[0][2] = 2'b01;
    release_reset();
    edges(8);
    chk("e_cnt3",  fifo_cnt_o, 3);
    chk("e_head",  evt_data_o, ev(0, 0, 0, 2, 1));
    reset_i = 1'b1;
    #1;
    chk("e_valid_rst", evt_valid_o, 0);
    chk("e_cnt_rst",   fifo_cnt_o, 0);
    chk("e_idle_rst",  idle_o, 1);
    apply_reset();
    evt_ready_i = 1'b1;
    release_reset();
    edges(6);
    chk("e_idle_after", idle_o, 1);

    // Pixel request in the wall-clock wrap cycle (255 -> 0)
    apply_reset();
    release_reset();
    edges(255);
    req[1][1] = 2'b01;
`ifdef PIXEL_AER_TS_WRAP_EN
    exp_q.push_back(ev(1, 0, 0, 0, 0));
    exp_q.push_back(ev(0, 1, 1, 1, 1));
`else
    exp_q.push_back(ev(0, 1, 1, 0, 1));
`endif
    edges(6);
    req = '0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
